// File: rtl/text_line_driver.sv
// text_line_driver
//   Character source placed directly upstream of the glyph renderer. It holds a one-line text
//   buffer that is filled through a valid/ready typewriter port. For every pixel of the incoming
//   stream it supplies the code and the cell origin covering that pixel, two cycles after the
//   pixel enters. The stream is forwarded with the same delay. A cursor cell blinks at frame rate.
//
// Ports
//   px_clk      pixel clock, all state on its rising edge
//   reset_n     asynchronous active-low reset
//   RGBStr_i    stream in: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [25:23] RGB
//   wr_valid    write request
//   wr_char     code to write (8'h0D = carriage return, 8'h08 = backspace)
//   wr_ready    write acceptance, high only while idle
//   clear       single-cycle request to blank the line
//   cursor      current cursor cell
//   character   code for the renderer
//   pos_x/pos_y cell origin for the renderer (pos_y = 10'h3FF parks the glyph off-screen)
//   RGBStr_o    RGBStr_i delayed by two cycles
module text_line_driver #(
    parameter int unsigned len          = 32,
    parameter int unsigned gsize        = 16,
    parameter logic [9:0]  line_x       = 10'd64,
    parameter logic [9:0]  line_y       = 10'd200,
    parameter int unsigned blink_frames = 30,
    parameter logic [7:0]  cursor_char  = 8'h5F,
    localparam int unsigned cw          = $clog2(len)
) (
    input  logic          px_clk,
    input  logic          reset_n,
    input  logic [25:0]   RGBStr_i,
    input  logic          wr_valid,
    input  logic [7:0]    wr_char,
    output logic          wr_ready,
    input  logic          clear,
    output logic [cw-1:0] cursor,
    output logic [7:0]    character,
    output logic [9:0]    pos_x,
    output logic [9:0]    pos_y,
    output logic [25:0]   RGBStr_o
);

    localparam int unsigned GShift = $clog2(gsize);
    localparam int unsigned LineW  = len * gsize;
    localparam int unsigned YEnd   = int'(line_y) + gsize;
    localparam int unsigned FrameW = (blink_frames > 1) ? $clog2(blink_frames) : 1;

    localparam logic [7:0] ChSpace = 8'h20;
    localparam logic [7:0] ChCr    = 8'h0D;
    localparam logic [7:0] ChBs    = 8'h08;

    typedef enum logic {StIdle, StClear} state_e;

    state_e          state_q, state_d;
    logic [cw-1:0]   clr_q, clr_d;
    logic [cw-1:0]   cursor_q, cursor_d;
    logic            wr_ready_q;

    // Line buffer (not reset)
    logic [7:0]      mem [len];
    logic            mem_we;
    logic [cw-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;
    logic [cw-1:0]   mem_raddr;
    logic [7:0]      rd_q;

    // Stage A: lookup
    logic [9:0]      xc, yc, dx;
    logic            in_line_a;
    logic            in_line_q;
    logic [cw-1:0]   idx_q;
    logic [25:0]     rgb_a_q;

    // Stage B: outputs
    logic [7:0]      char_q, char_d;
    logic [9:0]      pos_x_q, pos_x_d;
    logic [9:0]      pos_y_q, pos_y_d;
    logic [25:0]     rgb_b_q;

    // Blink
    logic            vs_q;
    logic [FrameW-1:0] frame_q;
    logic            blink_on_q;

    //--------------------------------------------------------------------------------------------
    // Control FSM and write port
    //--------------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        cursor_d  = cursor_q;
        mem_we    = 1'b0;
        mem_waddr = clr_q;
        mem_wdata = ChSpace;

        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                clr_d     = clr_q + cw'(1);
                if (clr_q == cw'(len - 1)) begin
                    state_d  = StIdle;
                    cursor_d = '0;
                end
            end
            StIdle: begin
                if (wr_valid && wr_ready_q) begin
                    case (wr_char)
                        ChCr: cursor_d = '0;
                        ChBs: begin
                            // Saturate at cell 0, then blank the cell we moved onto
                            if (cursor_q != '0) cursor_d = cursor_q - cw'(1);
                            mem_we    = 1'b1;
                            mem_waddr = cursor_d;
                            mem_wdata = ChSpace;
                        end
                        default: begin
                            mem_we    = 1'b1;
                            mem_waddr = cursor_q;
                            mem_wdata = wr_char;
                            cursor_d  = cursor_q + cw'(1);
                        end
                    endcase
                end
            end
            default: state_d = StClear;
        endcase

        // A clear always wins; any transfer this cycle is still written and later swept away
        if (clear) begin
            state_d = StClear;
            clr_d   = '0;
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StClear;
            clr_q      <= '0;
            cursor_q   <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            cursor_q   <= cursor_d;
            wr_ready_q <= (state_d == StIdle);
        end
    end

    // Synchronous read returns the old word on a same-address write
    always_ff @(posedge px_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_q <= mem[mem_raddr];
    end

    //--------------------------------------------------------------------------------------------
    // Stage A: cell lookup
    //--------------------------------------------------------------------------------------------
    assign xc = RGBStr_i[22:13];
    assign yc = RGBStr_i[12:3];
    assign dx = xc - line_x;

    assign in_line_a = (xc >= line_x) && (32'(dx) < LineW) &&
                       (yc >= line_y) && (32'(yc) < YEnd);
    assign mem_raddr = cw'(dx >> GShift);

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_line_q <= 1'b0;
            idx_q     <= '0;
            rgb_a_q   <= '0;
        end else begin
            in_line_q <= in_line_a;
            idx_q     <= mem_raddr;
            rgb_a_q   <= RGBStr_i;
        end
    end

    //--------------------------------------------------------------------------------------------
    // Stage B: character selection and cell origin
    //--------------------------------------------------------------------------------------------
    always_comb begin
        char_d  = ChSpace;
        pos_x_d = line_x;
        pos_y_d = 10'h3FF;
        if (in_line_q) begin
            pos_x_d = line_x + (10'(idx_q) << GShift);
            pos_y_d = line_y;
            if (idx_q == cursor_q && blink_on_q && state_q == StIdle) begin
                char_d = cursor_char;
            end else begin
                char_d = rd_q;
            end
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            char_q  <= ChSpace;
            pos_x_q <= '0;
            pos_y_q <= 10'h3FF;
            rgb_b_q <= '0;
        end else begin
            char_q  <= char_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            rgb_b_q <= rgb_a_q;
        end
    end

    //--------------------------------------------------------------------------------------------
    // Cursor blink: one count per VS rising edge
    //--------------------------------------------------------------------------------------------
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q       <= 1'b0;
            frame_q    <= '0;
            blink_on_q <= 1'b1;
        end else begin
            vs_q <= RGBStr_i[1];
            if (RGBStr_i[1] && !vs_q) begin
                if (frame_q == FrameW'(blink_frames - 1)) begin
                    frame_q    <= '0;
                    blink_on_q <= !blink_on_q;
                end else begin
                    frame_q <= frame_q + FrameW'(1);
                end
            end
        end
    end

    assign wr_ready  = wr_ready_q;
    assign cursor    = cursor_q;
    assign character = char_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign RGBStr_o  = rgb_b_q;

endmodule

// File: tb/tb_text_line_driver.sv
module tb_text_line_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [25:0] rgb_in;
    logic        wr_valid;
    logic [7:0]  wr_char;
    logic        wr_ready;
    logic        clear;
    logic [4:0]  cursor;
    logic [7:0]  character;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [25:0] rgb_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    typedef struct packed {
        logic [9:0] xc;
        logic [9:0] yc;
        logic [7:0] ch;
        logic [9:0] px;
        logic [9:0] py;
    } vec_t;

    vec_t        tab[$];
    logic [25:0] hist [1000];

    always #5 clk = ~clk;

    text_line_driver dut (
        .px_clk   (clk),
        .reset_n  (reset_n),
        .RGBStr_i (rgb_in),
        .wr_valid (wr_valid),
        .wr_char  (wr_char),
        .wr_ready (wr_ready),
        .clear    (clear),
        .cursor   (cursor),
        .character(character),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .RGBStr_o (rgb_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] pix(input logic [9:0] xc, input logic [9:0] yc,
                                        input logic vs);
        return {3'b101, xc, yc, 1'b0, vs, 1'b1};
    endfunction

    function automatic logic [9:0] cell_x(input int i);
        return 10'(64 + i * 16);
    endfunction

    function automatic logic blink_exp();
        return ((pulses / 30) % 2) == 0;
    endfunction

    // Single pixel lookup, sampled exactly two edges after it is presented
    task automatic check_cell(input int i, input logic [7:0] exp, input string name);
        @(negedge clk);
        rgb_in = pix(cell_x(i) + 10'd7, 10'd205, 1'b0);
        @(negedge clk);
        rgb_in = '0;
        @(negedge clk);
        chk(name, {24'd0, character}, {24'd0, exp});
        chk({name, "_posx"}, {22'd0, pos_x}, {22'd0, cell_x(i)});
    endtask

    task automatic write_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL write_timeout: got wr_ready=0, expected 1 within 200 cycles");
        end
        wr_char  = c;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        rgb_in = pix(10'd0, 10'd0, 1'b1);
        @(negedge clk);
        rgb_in = '0;
        pulses++;
    endtask

    initial begin
        vec_t v;
        logic [25:0] w;

        // Line contents "HI" followed by spaces, cursor at 2, blink off
        for (int x = 64; x < 96; x++) begin
            v.xc = 10'(x);
            v.yc = 10'd200 + 10'(x % 16);
            v.ch = (x < 80) ? 8'h48 : 8'h49;
            v.px = (x < 80) ? 10'd64 : 10'd80;
            v.py = 10'd200;
            tab.push_back(v);
        end
        tab.push_back('{xc: 10'd63,   yc: 10'd200, ch: 8'h20, px: 10'd64,  py: 10'h3FF});
        tab.push_back('{xc: 10'd70,   yc: 10'd216, ch: 8'h20, px: 10'd64,  py: 10'h3FF});
        tab.push_back('{xc: 10'd70,   yc: 10'd199, ch: 8'h20, px: 10'd64,  py: 10'h3FF});
        tab.push_back('{xc: 10'd576,  yc: 10'd200, ch: 8'h20, px: 10'd64,  py: 10'h3FF});
        tab.push_back('{xc: 10'd1023, yc: 10'd210, ch: 8'h20, px: 10'd64,  py: 10'h3FF});
        tab.push_back('{xc: 10'd575,  yc: 10'd200, ch: 8'h20, px: 10'd560, py: 10'd200});
        tab.push_back('{xc: 10'd100,  yc: 10'd215, ch: 8'h20, px: 10'd96,  py: 10'd200});

        reset_n  = 1'b0;
        rgb_in   = '0;
        wr_valid = 1'b0;
        wr_char  = '0;
        clear    = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_wr_ready",  {31'd0, wr_ready}, 32'd0);
        chk("rst_cursor",    {27'd0, cursor},   32'd0);
        chk("rst_character", {24'd0, character}, 32'h20);
        chk("rst_pos_x",     {22'd0, pos_x},    32'd0);
        chk("rst_pos_y",     {22'd0, pos_y},    32'h3FF);
        chk("rst_rgb_out",   {6'd0, rgb_out},   32'd0);

        // wr_ready low for 32 cycles after release, high on the 33rd
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            chk("ready_after_reset", {31'd0, wr_ready}, (k == 32) ? 32'd1 : 32'd0);
        end

        // Turn blink off, then every cell must be blank
        repeat (30) vs_pulse();
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20, "blank_cell");

        // "HI", then the vector table streamed back to back
        write_char(8'h48);
        write_char(8'h49);
        chk("cursor_after_hi", {27'd0, cursor}, 32'd2);
        for (int i = 0; i < int'(tab.size()) + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                v = tab[i-2];
                chk("tab_char", {24'd0, character}, {24'd0, v.ch});
                chk("tab_pos_x", {22'd0, pos_x}, {22'd0, v.px});
                chk("tab_pos_y", {22'd0, pos_y}, {22'd0, v.py});
            end
            if (i < int'(tab.size())) rgb_in = pix(tab[i].xc, tab[i].yc, 1'b0);
            else rgb_in = '0;
        end

        // Carriage return, wrap-around, backspace at cell 0
        write_char(8'h0D);
        chk("cursor_after_cr", {27'd0, cursor}, 32'd0);
        repeat (33) write_char(8'h41);
        chk("cursor_wrap", {27'd0, cursor}, 32'd1);
        check_cell(0, 8'h41, "wrap_cell0");
        check_cell(31, 8'h41, "wrap_cell31");
        write_char(8'h0D);
        chk("cursor_cr2", {27'd0, cursor}, 32'd0);
        write_char(8'h08);
        chk("cursor_bs_sat", {27'd0, cursor}, 32'd0);
        check_cell(0, 8'h20, "bs_cell0");
        check_cell(1, 8'h41, "bs_cell1");

        // Cursor to cell 3, then 60 frames of blink
        write_char(8'h0D);
        repeat (3) write_char(8'h41);
        chk("cursor_3", {27'd0, cursor}, 32'd3);
        check_cell(3, blink_exp() ? 8'h5F : 8'h41, "blink_start");
        for (int f = 0; f < 60; f++) begin
            vs_pulse();
            check_cell(3, blink_exp() ? 8'h5F : 8'h41, "blink_frame");
        end

        // Write and clear in the same cycle, with blink on
        while (!blink_exp()) vs_pulse();
        @(negedge clk);
        chk("ready_before_clear", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_char  = 8'h5A;
        clear    = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wr_valid = 1'b0;
                clear    = 1'b0;
                chk("cursor_after_wr_clr", {27'd0, cursor}, 32'd4);
                rgb_in = pix(cell_x(4), 10'd200, 1'b0);
            end else if (k == 2) begin
                rgb_in = pix(cell_x(3), 10'd200, 1'b0);
            end else begin
                rgb_in = '0;
            end
            if (k == 3) chk("no_overlay_in_clear", {24'd0, character}, 32'h41);
            if (k == 4) chk("handshake_written", {24'd0, character}, 32'h5A);
            chk("ready_during_clear", {31'd0, wr_ready}, (k == 33) ? 32'd1 : 32'd0);
        end
        chk("cursor_after_clear", {27'd0, cursor}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check_cell(i, (i == 0 && blink_exp()) ? 8'h5F : 8'h20, "cleared_cell");
        end

        // Stream passthrough delay on random words
        for (int i = 0; i < 1002; i++) begin
            @(negedge clk);
            if (i >= 2) chk("rgb_delay", {6'd0, rgb_out}, {6'd0, hist[i-2]});
            if (i < 1000) begin
                w       = 26'($urandom);
                hist[i] = w;
                rgb_in  = w;
            end else begin
                rgb_in = '0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case a wait never resolves
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
